// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 4-stage RV32I core.
//
// Sits between the execute pipeline register and the register-file write
// port. An accepted op is held in the M1 register for one cycle, where it
// uses the data bus. Its result then moves into the WB output registers.
// Sub-word stores need two bus cycles because the bus has no byte enables.
// The first cycle reads the word and stalls upstream. The second cycle
// writes back the merged word.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   valid_in          execute presents an op this cycle
//   opcode_in         op class (load / store / anything else)
//   funct3_in         access size and sign
//   rd_sel_in         destination register
//   write_enable_in   op writes rd
//   alu_result_in     effective address or ALU result
//   store_data_in     rs2 value
//   stall_out         upstream must hold its op this cycle
//   dmem_addr         word-aligned bus address
//   dmem_wen          bus write enable
//   dmem_data         bidirectional bus data; driven only while dmem_wen=1
//   write_enable_out  register-file write enable
//   rd_sel_out        register-file write address
//   wb_data_out       register-file write data
//   misalign_out      misaligned/illegal access flag, in the op's WB slot
module mem_stage #(
    parameter logic [6:0] LOAD_OPCODE  = 7'b0000011,
    parameter logic [6:0] STORE_OPCODE = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_sel_in,
    input  logic        write_enable_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    inout  wire  [31:0] dmem_data,
    output logic        write_enable_out,
    output logic [4:0]  rd_sel_out,
    output logic [31:0] wb_data_out,
    output logic        misalign_out
);

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_RMW_WRITE = 1'b1
    } state_t;

    state_t      r_state;

    // M1 register
    logic        r_m1_valid;
    logic [6:0]  r_m1_opcode;
    logic [2:0]  r_m1_funct3;
    logic [4:0]  r_m1_rd;
    logic        r_m1_we;
    logic [31:0] r_m1_alu;
    logic [31:0] r_m1_sdata;

    // merged word held for the write half of a read-modify-write
    logic [31:0] r_rmw_word;

    // WB output registers
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_mis;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_f3_ok;
    logic        w_misalign;
    logic        w_sub_store;
    logic        w_word_store;
    logic        w_stall;
    logic        w_wen;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;
    logic        w_wb_we;
    logic [31:0] w_wb_data;
    logic        w_wb_mis;

    // ------------------------------------------------------------------
    // Decode of the op sitting in M1
    // ------------------------------------------------------------------
    assign w_is_load  = r_m1_valid && (r_m1_opcode == LOAD_OPCODE);
    assign w_is_store = r_m1_valid && (r_m1_opcode == STORE_OPCODE);

    // Legal funct3: loads allow B/H/W/BU/HU, stores only B/H/W.
    always_comb begin
        w_f3_ok = 1'b0;
        if (w_is_load) begin
            w_f3_ok = (r_m1_funct3 == 3'b000) || (r_m1_funct3 == 3'b001) ||
                      (r_m1_funct3 == 3'b010) || (r_m1_funct3 == 3'b100) ||
                      (r_m1_funct3 == 3'b101);
        end else if (w_is_store) begin
            w_f3_ok = (r_m1_funct3 == 3'b000) || (r_m1_funct3 == 3'b001) ||
                      (r_m1_funct3 == 3'b010);
        end
    end

    // An illegal funct3 is reported the same way as a misaligned address.
    assign w_misalign = (w_is_load || w_is_store) &&
                        (!w_f3_ok ||
                         ((r_m1_funct3[1:0] == 2'b10) && (r_m1_alu[1:0] != 2'b00)) ||
                         ((r_m1_funct3[1:0] == 2'b01) && r_m1_alu[0]));

    assign w_sub_store  = w_is_store && !w_misalign && (r_m1_funct3[1:0] != 2'b10);
    assign w_word_store = w_is_store && !w_misalign && (r_m1_funct3[1:0] == 2'b10);

    assign w_stall = (r_state == ST_RUN) && w_sub_store;

    // Driven straight from state, so an asynchronous reset drops the
    // write at once.
    assign w_wen   = ((r_state == ST_RUN) && w_word_store) || (r_state == ST_RMW_WRITE);
    assign w_wdata = (r_state == ST_RMW_WRITE) ? r_rmw_word : r_m1_sdata;

    assign stall_out = w_stall;
    assign dmem_addr = {r_m1_alu[31:2], 2'b00};
    assign dmem_wen  = w_wen;
    assign dmem_data = w_wen ? w_wdata : 32'bz;

    // ------------------------------------------------------------------
    // Load lane extraction
    // ------------------------------------------------------------------
    assign w_shifted   = dmem_data >> {r_m1_alu[1:0], 3'b000};
    assign w_lane_byte = w_shifted[7:0];
    assign w_lane_half = r_m1_alu[1] ? dmem_data[31:16] : dmem_data[15:0];

    always_comb begin
        w_load_val = 32'd0;
        case (r_m1_funct3)
            3'b000:  w_load_val = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b001:  w_load_val = {{16{w_lane_half[15]}}, w_lane_half};
            3'b010:  w_load_val = dmem_data;
            3'b100:  w_load_val = {24'd0, w_lane_byte};
            3'b101:  w_load_val = {16'd0, w_lane_half};
            default: w_load_val = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store merge. Each byte lane takes new data if the SB/SH covers it,
    // otherwise it keeps the byte read from memory this cycle.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HI_OF_HALF = gi % 2;
            logic       w_hit;
            logic [7:0] w_src;
            assign w_hit = (r_m1_funct3[1:0] == 2'b00) ? (r_m1_alu[1:0] == 2'(gi))
                                                       : (r_m1_alu[1] == 1'(gi / 2));
            // An SH puts its upper byte into the odd lane of its half.
            assign w_src = ((HI_OF_HALF == 1) && r_m1_funct3[0]) ? r_m1_sdata[15:8]
                                                                 : r_m1_sdata[7:0];
            assign w_merged[gi*8 +: 8] = w_hit ? w_src : dmem_data[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next WB contents for a normal (non-stalled) RUN cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_wb_we   = 1'b0;
        w_wb_data = 32'd0;
        w_wb_mis  = 1'b0;
        if (r_m1_valid) begin
            if (w_misalign) begin
                w_wb_mis = 1'b1;
            end else if (w_is_load) begin
                w_wb_we   = r_m1_we && (r_m1_rd != 5'd0);
                w_wb_data = w_load_val;
            end else if (!w_is_store) begin
                w_wb_we   = r_m1_we && (r_m1_rd != 5'd0);
                w_wb_data = r_m1_alu;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, M1 and WB registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_m1_valid  <= 1'b0;
            r_m1_opcode <= 7'd0;
            r_m1_funct3 <= 3'd0;
            r_m1_rd     <= 5'd0;
            r_m1_we     <= 1'b0;
            r_m1_alu    <= 32'd0;
            r_m1_sdata  <= 32'd0;
            r_rmw_word  <= 32'd0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_mis    <= 1'b0;
        end else begin
            // M1 holds the sub-word store through its read cycle. It reloads
            // in every other cycle, including the RMW write cycle.
            if (!w_stall) begin
                r_m1_valid  <= valid_in;
                r_m1_opcode <= opcode_in;
                r_m1_funct3 <= funct3_in;
                r_m1_rd     <= rd_sel_in;
                r_m1_we     <= write_enable_in;
                r_m1_alu    <= alu_result_in;
                r_m1_sdata  <= store_data_in;
            end

            r_wb_rd <= r_m1_rd;
            if (r_state == ST_RUN) begin
                if (w_stall) begin
                    r_rmw_word <= w_merged;
                    r_state    <= ST_RMW_WRITE;
                    r_wb_we    <= 1'b0;
                    r_wb_data  <= 32'd0;
                    r_wb_mis   <= 1'b0;
                end else begin
                    r_wb_we    <= w_wb_we;
                    r_wb_data  <= w_wb_data;
                    r_wb_mis   <= w_wb_mis;
                end
            end else begin
                r_state   <= ST_RUN;
                r_wb_we   <= 1'b0;
                r_wb_data <= 32'd0;
                r_wb_mis  <= 1'b0;
            end
        end
    end

    assign write_enable_out = r_wb_we;
    assign rd_sel_out       = r_wb_rd;
    assign wb_data_out      = r_wb_data;
    assign misalign_out     = r_wb_mis;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. A reference model works out the
// expected result of each op at acceptance time, from the access rules and
// a word-array memory. It files the expected per-cycle outputs in tables
// indexed by clock-edge number. A negedge monitor compares the DUT outputs
// against those tables.
module tb_mem_stage;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;
    localparam logic [6:0]  OP_ALUI  = 7'b0010011;
    localparam int          N        = 4096;
    localparam logic [31:0] BASE     = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [6:0]  opcode_in = '0;
    logic [2:0]  funct3_in = '0;
    logic [4:0]  rd_sel_in = '0;
    logic        write_enable_in = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] store_data_in = '0;
    logic        stall_out;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    wire  [31:0] dmem_data;
    logic        write_enable_out;
    logic [4:0]  rd_sel_out;
    logic [31:0] wb_data_out;
    logic        misalign_out;

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .opcode_in        (opcode_in),
        .funct3_in        (funct3_in),
        .rd_sel_in        (rd_sel_in),
        .write_enable_in  (write_enable_in),
        .alu_result_in    (alu_result_in),
        .store_data_in    (store_data_in),
        .stall_out        (stall_out),
        .dmem_addr        (dmem_addr),
        .dmem_wen         (dmem_wen),
        .dmem_data        (dmem_data),
        .write_enable_out (write_enable_out),
        .rd_sel_out       (rd_sel_out),
        .wb_data_out      (wb_data_out),
        .misalign_out     (misalign_out)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Bus-side memory: 16 words at BASE. It reads combinationally and
    // commits writes on the clock edge.
    logic [31:0] mem_bus [16];
    logic        bus_clr = 1'b1;
    assign dmem_data = dmem_wen ? 32'bz : mem_bus[dmem_addr[5:2]];
    always @(posedge clk) begin
        if (bus_clr) begin
            for (int i = 0; i < 16; i++) mem_bus[i] <= 32'd0;
        end else if (dmem_wen) begin
            mem_bus[dmem_addr[5:2]] <= dmem_data;
        end
    end

    // Expected outputs per edge number.
    logic        e_stall [N];
    logic        e_wen   [N];
    logic [31:0] e_wdata [N];
    logic        e_av    [N];
    logic [31:0] e_addr  [N];
    logic        e_we    [N];
    logic [4:0]  e_rd    [N];
    logic [31:0] e_data  [N];
    logic        e_mis   [N];
    logic [31:0] ref_mem [16];

    int   total = 0;
    int   bad = 0;
    logic chk_en = 1'b0;
    int   last_acc = 0;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] sd;
    } op_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                               input logic we, input logic [31:0] alu, input logic [31:0] sd);
        op_t o;
        o.opc = opc; o.f3 = f3; o.rd = rd; o.we = we; o.alu = alu; o.sd = sd;
        return o;
    endfunction

    task automatic clear_exp(input int from);
        for (int i = from; i < N; i++) begin
            e_stall[i] = 1'b0; e_wen[i] = 1'b0; e_wdata[i] = 32'd0;
            e_av[i] = 1'b0; e_addr[i] = 32'd0;
            e_we[i] = 1'b0; e_rd[i] = 5'd0; e_data[i] = 32'd0; e_mis[i] = 1'b0;
        end
    endtask

    // Reference model. It runs each op in program order at its acceptance
    // edge a: bus activity in cycle a (and a+1 for SB/SH), result at a+1.
    task automatic model_accept(input op_t o, input int a);
        logic        is_ld, is_st, ok, mis, sgn;
        int          size, off, idx;
        logic [31:0] w, v;
        is_ld = (o.opc == OP_LOAD);
        is_st = (o.opc == OP_STORE);
        off   = int'(o.alu[1:0]);
        idx   = int'(o.alu[5:2]);
        sgn   = !o.f3[2];
        case (o.f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 8;
        endcase
        ok  = is_ld ? (o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (o.f3 inside {3'd0, 3'd1, 3'd2});
        mis = (is_ld || is_st) && (!ok || (off % size != 0));
        if (a + 2 < N) begin
            e_rd[a+1]  = o.rd;
            e_mis[a+1] = mis;
            if (is_ld || is_st) begin
                e_av[a] = 1'b1;
                e_addr[a] = o.alu & 32'hFFFF_FFFC;
            end
            if (is_ld) begin
                if (!mis) begin
                    w = ref_mem[idx];
                    v = w >> (8 * off);
                    if (size == 1) begin
                        v = v & 32'h0000_00FF;
                        if (sgn && v >= 32'd128) v = v - 32'd256;
                    end else if (size == 2) begin
                        v = v & 32'h0000_FFFF;
                        if (sgn && v >= 32'd32768) v = v - 32'd65536;
                    end
                    e_we[a+1]   = o.we && (o.rd != 5'd0);
                    e_data[a+1] = v;
                end
            end else if (is_st) begin
                if (!mis) begin
                    w = ref_mem[idx];
                    for (int b = 0; b < size; b++) begin
                        w = (w & ~(32'h0000_00FF << (8 * (off + b)))) |
                            (((o.sd >> (8 * b)) & 32'h0000_00FF) << (8 * (off + b)));
                    end
                    ref_mem[idx] = w;
                    if (size == 4) begin
                        e_wen[a] = 1'b1; e_wdata[a] = w;
                    end else begin
                        e_stall[a]   = 1'b1;
                        e_wen[a+1]   = 1'b1;
                        e_wdata[a+1] = w;
                        e_av[a+1]    = 1'b1;
                        e_addr[a+1]  = o.alu & 32'hFFFF_FFFC;
                    end
                end
            end else begin
                e_we[a+1]   = o.we && (o.rd != 5'd0);
                e_data[a+1] = o.alu;
            end
        end
    endtask

    // Present one op and hold it until accepted (stall_out low at the edge).
    task automatic drive_op(input op_t o);
        logic st;
        int   g;
        opcode_in = o.opc; funct3_in = o.f3; rd_sel_in = o.rd;
        write_enable_in = o.we; alu_result_in = o.alu; store_data_in = o.sd;
        valid_in = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            st = stall_out;
            @(posedge clk);
            #1;
            g++;
        end while (st && g < 4);
        chk("accept_bound", 32'(st), 32'd0);
        model_accept(o, edge_cnt);
        last_acc = edge_cnt;
        $display("op opc=%b f3=%0d rd=%0d we=%0b alu=%h sd=%h accepted@%0d",
                 o.opc, o.f3, o.rd, o.we, o.alu, o.sd, edge_cnt);
        valid_in = 1'b0;
    endtask

    // Idle cycles with junk on the data inputs; valid_in=0 must make them bubbles.
    task automatic idle(input int n);
        valid_in = 1'b0;
        opcode_in = OP_STORE; funct3_in = 3'd0; rd_sel_in = 5'd3;
        write_enable_in = 1'b1; alu_result_in = $urandom; store_data_in = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(write_enable_out), 32'd0);
        chk({tag, "_rd"},    32'(rd_sel_out),       32'd0);
        chk({tag, "_data"},  wb_data_out,           32'd0);
        chk({tag, "_mis"},   32'(misalign_out),     32'd0);
        chk({tag, "_wen"},   32'(dmem_wen),         32'd0);
        chk({tag, "_stall"}, 32'(stall_out),        32'd0);
    endtask

    // Per-cycle monitor.
    always @(negedge clk) begin
        if (chk_en && rst_n && edge_cnt < N) begin
            chk("stall_out", 32'(stall_out), 32'(e_stall[edge_cnt]));
            chk("dmem_wen",  32'(dmem_wen),  32'(e_wen[edge_cnt]));
            if (e_wen[edge_cnt]) chk("dmem_wdata", dmem_data, e_wdata[edge_cnt]);
            if (e_av[edge_cnt])  chk("dmem_addr",  dmem_addr, e_addr[edge_cnt]);
            chk("wb_we",    32'(write_enable_out), 32'(e_we[edge_cnt]));
            chk("misalign", 32'(misalign_out),     32'(e_mis[edge_cnt]));
            if (e_we[edge_cnt]) begin
                chk("rd_sel",  32'(rd_sel_out), 32'(e_rd[edge_cnt]));
                chk("wb_data", wb_data_out,     e_data[edge_cnt]);
            end
        end
    end

    initial begin
        logic [31:0] saved;
        clear_exp(0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

        // Reset state
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_clr = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Directed steps
        drive_op(mk(OP_ALU,   3'd0, 5'd5, 1'b1, 32'h0000_1234, 32'd0));      // ADD
        drive_op(mk(OP_STORE, 3'd2, 5'd0, 1'b0, BASE, 32'h80FF_7F01));       // SW
        drive_op(mk(OP_LOAD,  3'd0, 5'd1, 1'b1, BASE + 32'd2, 32'd0));       // LB
        drive_op(mk(OP_LOAD,  3'd4, 5'd2, 1'b1, BASE + 32'd3, 32'd0));       // LBU
        drive_op(mk(OP_LOAD,  3'd1, 5'd3, 1'b1, BASE + 32'd2, 32'd0));       // LH
        drive_op(mk(OP_LOAD,  3'd2, 5'd4, 1'b1, BASE, 32'd0));               // LW
        drive_op(mk(OP_LOAD,  3'd5, 5'd6, 1'b1, BASE + 32'd2, 32'd0));       // LHU
        drive_op(mk(OP_STORE, 3'd2, 5'd0, 1'b0, BASE, 32'h1122_3344));       // SW
        drive_op(mk(OP_STORE, 3'd0, 5'd0, 1'b0, BASE + 32'd1, 32'h0000_00AB)); // SB
        drive_op(mk(OP_LOAD,  3'd2, 5'd7, 1'b1, BASE, 32'd0));               // LW back-to-back
        drive_op(mk(OP_STORE, 3'd1, 5'd0, 1'b0, BASE + 32'd1, 32'h0000_BEEF)); // SH misaligned
        drive_op(mk(OP_LOAD,  3'd2, 5'd8, 1'b1, BASE + 32'd2, 32'd0));       // LW misaligned
        idle(2);
        drive_op(mk(OP_LOAD,  3'd2, 5'd9,  1'b1, BASE, 32'd0));              // LW
        drive_op(mk(OP_ALU,   3'd0, 5'd10, 1'b1, 32'hDEAD_0001, 32'd0));     // ADD
        drive_op(mk(OP_STORE, 3'd2, 5'd0,  1'b0, BASE + 32'd8, 32'hCAFE_F00D)); // SW
        drive_op(mk(OP_LOAD,  3'd0, 5'd11, 1'b1, BASE + 32'd1, 32'd0));      // LB
        drive_op(mk(OP_LOAD,  3'd2, 5'd0,  1'b1, BASE + 32'd8, 32'd0));      // rd=0
        drive_op(mk(OP_LOAD,  3'd3, 5'd12, 1'b1, BASE + 32'd8, 32'd0));      // bad funct3
        drive_op(mk(OP_STORE, 3'd1, 5'd0,  1'b0, BASE + 32'd10, 32'h0000_7E57)); // SH aligned
        drive_op(mk(OP_LOAD,  3'd1, 5'd13, 1'b1, BASE + 32'd10, 32'd0));     // LH back
        idle(1);

        // Randomized mix
        for (int k = 0; k < 200; k++) begin
            op_t o;
            int  kind;
            kind  = $urandom_range(0, 9);
            o.rd  = 5'($urandom_range(0, 31));
            o.we  = ($urandom_range(0, 7) != 0);
            o.sd  = $urandom;
            o.alu = BASE | 32'($urandom_range(0, 63));
            if (kind < 3) begin
                o.opc = (kind == 0) ? OP_ALUI : OP_ALU;
                o.f3  = 3'($urandom_range(0, 7));
                o.alu = $urandom;
            end else if (kind < 7) begin
                o.opc = OP_LOAD;
                o.f3  = 3'($urandom_range(0, 7));
            end else begin
                o.opc = OP_STORE;
                o.f3  = 3'($urandom_range(0, 3));
            end
            drive_op(o);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);

        // Reset during the write half of an RMW: the write must not land.
        drive_op(mk(OP_STORE, 3'd2, 5'd0, 1'b0, BASE + 32'h14, 32'h5566_7788));
        saved = ref_mem[5];
        drive_op(mk(OP_STORE, 3'd0, 5'd0, 1'b0, BASE + 32'h16, 32'h0000_0099));
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        chk("rmw_wen_before_reset", 32'(dmem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        ref_mem[5] = saved;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_exp(edge_cnt);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive_op(mk(OP_LOAD, 3'd2, 5'd14, 1'b1, BASE + 32'h14, 32'd0));
        idle(4);

        // Final memory image must match the model.
        for (int i = 0; i < 16; i++) chk("mem_image", mem_bus[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
